// File: rtl/alu32_seqmul.sv
// 32-bit execute-stage ALU. Seven operations are purely combinational.
// MUL is a shift-add multiplier that retires one multiplier bit per clock.
// A new multiply starts on the first edge that sees aluop=MUL while idle.
// The product is on result after the 33rd edge. There is no busy flag, so
// the consumer must wait out that latency.
module alu32_seqmul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // When cnt_q equals this value, the current RUN edge performs the 32nd
    // iteration.
    localparam logic [5:0] LAST_ITER = 6'd31;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ma_q, ma_d;   // shifted multiplicand
    logic [WIDTH-1:0] mb_q, mb_d;   // shifted multiplier
    logic [WIDTH-1:0] p_q, p_d;     // running product
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] la_q, la_d;   // operands captured at start
    logic [WIDTH-1:0] lb_q, lb_d;

    logic is_mul;
    assign is_mul = (aluop == OP_MUL);

    // Multiplier sequencing: load on start, then one shift-add per edge.
    // Only the low WIDTH bits of the unsigned product are kept. These bits
    // equal the signed product modulo 2^WIDTH, so no sign fix-up is needed.
    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        la_d    = la_q;
        lb_d    = lb_q;
        case (state_q)
            S_IDLE: begin
                if (is_mul) begin
                    ma_d    = a;
                    mb_d    = b;
                    la_d    = a;
                    lb_d    = b;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!is_mul) begin
                    // Abort: the partial product is left visible in P.
                    state_d = S_IDLE;
                end else begin
                    if (mb_q[0]) begin
                        p_d = p_q + ma_q;
                    end
                    ma_d  = ma_q << 1;
                    mb_d  = mb_q >> 1;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Hold P until the request changes. The next MUL edge then
                // starts a new multiply.
                if (!is_mul || (a != la_q) || (b != lb_q)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Multiplier state registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            la_q    <= '0;
            lb_q    <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
        end
    end

    // Result mux. Every path except MUL is combinational. MUL shows P,
    // including the partial values while the multiply is still running.
    always_comb begin
        result = '0;
        case (aluop)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_MUL: result = p_q;
            OP_XOR: result = a ^ b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu32_seqmul.sv
// Directed bench for alu32_seqmul.
// A behavioural model follows the multiply as "RUN edges done" and computes
// the visible product arithmetically. A per-cycle compare process checks
// the DUT against that model. Directed literal checks pin the model to
// hand-computed values.
module tb_alu32_seqmul;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  aluop;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    alu32_seqmul dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .aluop  (aluop),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_active = 1'b0;  // a multiply is in flight or finished
    int          m_k      = 0;     // RUN edges completed
    logic [31:0] m_la     = '0;
    logic [31:0] m_lb     = '0;
    logic [31:0] m_hold   = '0;    // P when no multiply is active

    // After k multiplier bits, P holds la * (low k bits of lb) mod 2^32.
    function automatic logic [31:0] partial(logic [31:0] x, logic [31:0] y, int k);
        logic [63:0] mask;
        logic [63:0] prod;
        mask = (k >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << k) - 64'd1);
        prod = {32'd0, x} * ({32'd0, y} & mask);
        return prod[31:0];
    endfunction

    function automatic logic [31:0] alu_ref(logic [31:0] x, logic [31:0] y, logic [2:0] op);
        case (op)
            3'b000: return x + y;
            3'b001: return x - y;
            3'b011: return x ^ y;
            3'b100: return x & y;
            3'b101: return x | y;
            3'b110: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b111: return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_la     = '0;
            m_lb     = '0;
            m_hold   = '0;
        end else if (!m_active) begin
            if (aluop == 3'b010) begin
                m_active = 1'b1;
                m_k      = 0;
                m_la     = a;
                m_lb     = b;
            end
        end else if (m_k < 32) begin
            if (aluop != 3'b010) begin
                m_hold   = partial(m_la, m_lb, m_k);
                m_active = 1'b0;
            end else begin
                m_k = m_k + 1;
            end
        end else begin
            if (aluop != 3'b010 || a != m_la || b != m_lb) begin
                m_hold   = m_la * m_lb;
                m_active = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp,
                         input bit quiet);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: result=%h expected=%h (t=%0t)", name, got, exp, $time);
        end else if (!quiet) begin
            $display("ok   %s: result=%h", name, got);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (aluop == 3'b010)
            exp = m_active ? partial(m_la, m_lb, m_k) : m_hold;
        else
            exp = alu_ref(a, b, aluop);
        check("cycle", result, exp, 1'b1);
    end

    // Inputs change 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_mul(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp);
        aluop = 3'b000;
        step(1);                  // leave DONE and go to IDLE
        a = x;
        b = y;
        aluop = 3'b010;
        step(33);
        check(name, result, exp, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        a = 32'd12;
        b = 32'd8;
        aluop = 3'b000;
        #2;
        check("add_12_8", result, 32'd20, 1'b0);
        aluop = 3'b001; #1;
        check("sub_12_8", result, 32'd4, 1'b0);
        aluop = 3'b011; #1;
        check("xor_12_8", result, 32'd4, 1'b0);
        aluop = 3'b100; #1;
        check("and_12_8", result, 32'd8, 1'b0);
        aluop = 3'b101; #1;
        check("or_12_8", result, 32'd12, 1'b0);
        aluop = 3'b110; #1;
        check("slt_12_8", result, 32'd0, 1'b0);
        aluop = 3'b111; #1;
        check("nor_12_8", result, 32'hFFFF_FFF3, 1'b0);
        aluop = 3'b010; #1;
        check("mul_in_reset", result, 32'd0, 1'b0);

        // Release reset with MUL already selected.
        step(2);
        rst = 1'b1;
        step(33);
        check("mul_12_8", result, 32'd96, 1'b0);
        step(7);
        check("mul_12_8_hold", result, 32'd96, 1'b0);

        // Operand change in DONE restarts: 1 edge to IDLE + 33 edges.
        b = 32'd5;
        step(34);
        check("mul_restart_12_5", result, 32'd60, 1'b0);

        // Signed operations.
        a = 32'hFFFF_FFFD; b = 32'd7; aluop = 3'b000; #1;
        check("add_m3_7", result, 32'd4, 1'b0);
        step(1);
        aluop = 3'b010;
        step(33);
        check("mul_m3_7", result, 32'hFFFF_FFEB, 1'b0);

        aluop = 3'b110; a = 32'hFFFF_FFFB; b = 32'd3; #1;
        check("slt_m5_3", result, 32'd1, 1'b0);
        a = 32'd3; b = 32'hFFFF_FFFB; #1;
        check("slt_3_m5", result, 32'd0, 1'b0);
        a = 32'd7; b = 32'd7; #1;
        check("slt_equal", result, 32'd0, 1'b0);
        aluop = 3'b000; a = 32'h7FFF_FFFF; b = 32'd1; #1;
        check("add_wrap", result, 32'h8000_0000, 1'b0);
        aluop = 3'b001; a = 32'd0; b = 32'd1; #1;
        check("sub_wrap", result, 32'hFFFF_FFFF, 1'b0);

        run_mul("mul_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        run_mul("mul_ovf_zero", 32'h8000_0000, 32'd2, 32'd0);

        // Reset at cycle 10 of a multiply.
        aluop = 3'b000;
        step(1);
        a = 32'd1000; b = 32'd1000; aluop = 3'b010;
        step(10);
        rst = 1'b0; #1;
        check("mul_async_reset", result, 32'd0, 1'b0);
        step(2);
        rst = 1'b1;
        step(33);
        check("mul_1000_1000", result, 32'd1000000, 1'b0);

        // Leaving MUL mid-run: the combinational result appears at once.
        aluop = 3'b000;
        step(1);
        a = 32'd12; b = 32'd8; aluop = 3'b010;
        step(10);
        aluop = 3'b000; #1;
        check("abort_shows_add", result, 32'd20, 1'b0);
        step(1);
        aluop = 3'b010;
        step(33);
        check("mul_after_abort", result, 32'd96, 1'b0);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu32_seqmul.md
Name: alu32_seqmul

Overview:
- 32-bit ALU with eight operations selected by a 3-bit opcode.
- Seven operations are single-cycle combinational paths.
- Multiply uses an internal sequential shift-add multiplier, one partial-product bit per clock.
- Sits in the datapath execute stage; the result is exposed on one 32-bit bus.

Parameters:
- WIDTH, 32, operand/result width. Fixed at 32; the iteration counter is sized for 32 steps.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- a  input  32  operand A, two's complement.
- b  input  32  operand B, two's complement.
- aluop  input  3  operation select.
- result  output  32  operation result, two's complement.

Behaviour:
- Opcode map:
  - 000 ADD: a+b, wraps mod 2^32, no overflow flag.
  - 001 SUB: a-b, wraps mod 2^32.
  - 010 MUL: low 32 bits of a*b.
  - 011 XOR: a^b.
  - 100 AND: a&b.
  - 101 OR: a|b.
  - 110 SLT: 1 if signed a < signed b, else 0, zero-extended.
  - 111 NOR: ~(a|b).
- Non-MUL opcodes: result is purely combinational from a, b, aluop; same-delta update, no clock needed.
- MUL result: result = product register P (registered output of the multiplier).
- Multiplier state: FSM IDLE/RUN/DONE; registers Ma (32), Mb (32), P (32), cnt (6), plus latched op snapshots la, lb.
- Reset (rst=0, asynchronous): FSM to IDLE; P, Ma, Mb, cnt, la, lb cleared to 0. result is 0 while aluop=010; other opcodes stay combinational.
- IDLE: on a rising edge with aluop=010:
  - load Ma=a, Mb=b, la=a, lb=b, P=0, cnt=0;
  - go to RUN.
- RUN: each edge:
  - if Mb[0]=1 then P=P+Ma (mod 2^32);
  - Ma<<=1, Mb>>=1 (logical), cnt++;
  - after the 32nd iteration (cnt reaches 32) go to DONE.
- Signedness: no sign correction is needed; the low 32 bits of the unsigned product equal the signed product mod 2^32.
- Latency: the start edge plus 32 RUN edges; the final product is on result after the 33rd rising edge following the first edge that sees aluop=010.
- Visibility during RUN: result shows the partial P, not valid until DONE.
- DONE: P held stable.
  - If aluop≠010, or a≠la, or b≠lb, return to IDLE; P keeps its value.
  - A new multiply then starts on the next edge where aluop=010.
- aluop leaving 010 during RUN: multiplication aborts to IDLE; P retains its partial value.
- Operand change during RUN: ignored; the operation uses the values latched at start. DONE then detects the mismatch and restarts.
- Reset mid-RUN: immediate abort, all state cleared.
- No busy/done output; the consumer waits ≥33 cycles after selecting MUL.

Test Plan:
- a=12, b=8, aluop=000 -> result=20; aluop=001 -> result=4.
- a=12, b=8, aluop=010; pulse rst low then release; run 40 clocks -> result=96 after 33 edges and stable thereafter; result=0 while rst is low.
- a=12, b=8: aluop=011 -> 4; 100 -> 8; 101 -> 12; 110 -> 0; 111 -> 0xFFFFFFF3 (-13).
- Signed cases:
  - a=-3, b=7, MUL -> -21 (0xFFFFFFEB) after 33 edges;
  - a=-5, b=3, SLT -> 1;
  - a=0x7FFFFFFF, b=1, ADD -> 0x80000000 (wrap).
- Assert rst low at cycle 10 of a MUL (a=1000, b=1000) -> result drops to 0 asynchronously; after release, the multiply restarts and yields 1000000 after 33 edges.
- Change b from 8 to 5 in DONE with aluop=010 -> FSM restarts and result becomes 60 after 34 edges. Switching aluop to 000 mid-RUN -> result immediately shows a+b.
